// File: rtl/seqgen_85.sv
// Serial frame transmitter: sends an 8-bit sync word followed by a latched payload,
// both MSB first, one bit per clock. Outputs decode only from registered state.
module seqgen_85 #(
    parameter logic [7:0]  SYNC  = 8'h85,
    parameter int unsigned PAY_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [PAY_W-1:0] Data,
    output logic             OutA,
    output logic             Valid,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_PAY  = 2'd2
    } state_t;

    localparam logic [3:0] SYNC_LAST = 4'd7;
    localparam logic [3:0] PAY_LAST  = 4'(PAY_W - 1);

    state_t           state, state_nx;
    logic [3:0]       cnt, cnt_nx;
    logic [PAY_W-1:0] shreg, shreg_nx;
    logic             done_nx;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            shreg <= '0;
            Done  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            shreg <= shreg_nx;
            Done  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        shreg_nx = shreg;
        done_nx  = 1'b0;
        OutA     = 1'b0;
        Valid    = 1'b0;
        Busy     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    shreg_nx = Data;
                    cnt_nx   = SYNC_LAST;
                    state_nx = ST_SYNC;
                end
            end
            ST_SYNC: begin
                OutA  = SYNC[cnt[2:0]];
                Valid = 1'b1;
                Busy  = 1'b1;
                if (cnt == 4'd0) begin
                    cnt_nx   = PAY_LAST;
                    state_nx = ST_PAY;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            ST_PAY: begin
                OutA     = shreg[PAY_W-1];
                Valid    = 1'b1;
                Busy     = 1'b1;
                shreg_nx = shreg << 1;
                if (cnt == 4'd0) begin
                    // cnt parks at zero so the idle state matches the reset state
                    state_nx = ST_IDLE;
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
                shreg_nx = '0;
            end
        endcase
    end

endmodule

// File: doc/seqgen_85.md
# seqgen_85

Serial frame transmitter that drives the single-bit line decoded by the 0x85 sequence detector. On a Start request it shifts out the 8-bit sync word (default 8'h85), MSB first, one bit per clock, followed by a latched payload word, MSB first. It sits at the transmit end of the serial link, so a detector watching OutA flags every sync word this block sends.

## Interface
- SYNC, 8'h85: sync word sent ahead of every payload. Fixed at 8 bits.
- PAY_W, 8: payload width in bits. Legal range 1..16.
- Clk  in  1  single clock. All flops are rising-edge.
- Reset  in  1  asynchronous, active-low reset. Flops clear immediately on Reset=0 and leave reset on the first rising Clk edge after Reset=1.
- Start  in  1  frame request. Sampled only when Busy=0.
- Data  in  PAY_W  payload. Captured on the edge that accepts Start.
- OutA  out  1  serial data line. Carries 0 whenever Valid=0.
- Valid  out  1  high while OutA carries a frame bit.
- Busy  out  1  high from the cycle after acceptance through the last payload bit.
- Done  out  1  one-cycle pulse in the cycle after the last payload bit.

## Operation
- FSM states are IDLE, SYNC and PAY. There is a 4-bit bit counter `cnt` and a PAY_W-bit payload shift register.
- IDLE: OutA=0, Valid=0, Busy=0.
  - Start=1 at an edge: latch Data into the shift register, set cnt=7, go to SYNC.
  - Start=0: stay in IDLE.
- SYNC: OutA=SYNC[cnt], Valid=1, Busy=1. On each edge cnt decrements.
  - When cnt=0 at an edge: set cnt=PAY_W-1 and go to PAY.
- PAY: OutA = shift register MSB, Valid=1, Busy=1. On each edge the register shifts left with zero fill and cnt decrements.
  - When cnt=0 at an edge: go to IDLE and set Done=1 for exactly one cycle.
- Start while Busy=1 is ignored and not queued. Data changes while Busy=1 have no effect on the frame in flight.
- Start is accepted in the Done cycle, because Busy=0 then. Back-to-back frames are therefore separated by exactly one idle cycle with OutA=0.
- All outputs are registered, or decoded from registered state only. There is no combinational path from Start or Data to any output.
- Width rules:
  - cnt is 4 bits, which covers PAY_W up to 16.
  - PAY_W-1 is truncated to 4 bits.
  - No arithmetic is done on Data.
- Unreachable state encodings return to IDLE on the next edge with all outputs low.
- Reset asserted mid-frame:
  - Outputs drop immediately to OutA=0, Valid=0, Busy=0, Done=0.
  - The FSM goes to IDLE and the partial frame is discarded.
  - There is no Done pulse for the aborted frame.

## Timing
- Reset values: OutA=0, Valid=0, Busy=0, Done=0, state=IDLE, cnt=0, shift register=0.
- Call the Start-accepting edge E0. Then:
  - First sync bit (SYNC[7]) is on OutA in the cycle after E0.
  - Sync bit k appears in cycle k+1, for k=0..7, counted MSB first.
  - Payload bit j appears in cycle 9+j, for j=0..PAY_W-1, counted MSB first.
  - Done=1 in cycle 9+PAY_W. Busy and Valid are 0 in that cycle.
- Frame length is 8+PAY_W Valid cycles. Request-to-first-bit latency is 1 cycle. Minimum period between accepted Starts is 9+PAY_W cycles.
- A detector clocked on Clk and fed OutA asserts its match one cycle after SYNC[0] is on the line. That is cycle 9, which is also the cycle of payload bit 0.

## Test plan
- Reset, then Start=1 with Data=8'hA5 for one cycle -> OutA over cycles 1..16 = 1000_0101_1010_0101, Valid=1 throughout, Done=1 in cycle 17 only.
- Hold Start=1 continuously with Data=8'h3C -> frames repeat with exactly one OutA=0/Valid=0 gap cycle, and Done pulses every 17 cycles.
- Start pulses at cycles 3 and 10 after acceptance, with Data changed to 8'hFF during the frame -> second Start is ignored, payload is still the originally latched value, only one Done pulse.
- Drop Reset to 0 during payload bit 4 -> OutA, Valid and Busy are 0 immediately; no Done pulse; after Reset returns to 1, a Start sends a full correct frame.
- Instantiate with PAY_W=3 and Data=3'b101 -> 11 Valid cycles with OutA = 1000_0101_101, Done in cycle 12.
- Connect OutA to the 0x85 sequence detector and send a frame with Data=8'h00 -> detector match asserts exactly once, in cycle 9.
